mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Memory-stage engine consuming the decoder's memory controls (isMemRead, isMemWrite, memMode) plus the computed address and store data.
- Issues one transaction per accepted op on the data-bus request/response interface.
- Generates byte strobes and lane-shifted write data; aligns and sign/zero-extends load data.
- Stalls the pipeline via in_ready until the transaction completes.

Parameters:
- XLEN, 64, data/address width; only 64 is supported.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset; block is in reset while reset==0
- in_valid  in  1  memory-stage op presented
- in_ready  out  1  unit idle, op accepted this cycle if in_valid
- is_mem_read  in  1  load op (decoder isMemRead)
- is_mem_write  in  1  store op (decoder isMemWrite)
- mem_mode  in  4  [3]=write, [2:0]=funct3 (decoder memMode)
- addr  in  64  effective byte address
- wdata  in  64  store data, right-aligned
- dreq_valid  out  1  bus request valid
- dreq_addr  out  64  request address, equal to latched addr
- dreq_size  out  3  log2 bytes: 0=1B, 1=2B, 2=4B, 3=8B
- dreq_strobe  out  8  byte write enables; 0 for loads
- dreq_data  out  64  lane-shifted store data
- dresp_addr_ok  in  1  request accepted
- dresp_data_ok  in  1  data returned / write done
- dresp_data  in  64  raw 8-byte-aligned read data
- out_valid  out  1  one-cycle completion pulse
- out_rdata  out  64  extended load result
- out_fault  out  1  misaligned or illegal mode; qualifies out_valid

Behaviour:
- Reset values: dreq_valid=0, out_valid=0, out_fault=0, out_rdata=0, dreq_addr/data/strobe/size=0, in_ready=1, state=IDLE.
- Reset mid-transaction: immediate return to IDLE; a pending bus response is ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - in_ready=1. On in_valid, latch all inputs.
  - Neither read nor write: go to DONE, out_rdata=0, fault=0.
  - Fault: go to DONE with out_fault=1; no bus request. Fault cases:
    - address not aligned to its size (addr[size-1:0]≠0);
    - load funct3=111;
    - store funct3[2]=1.
  - Otherwise: go to REQ.
- REQ:
  - dreq_valid=1; all dreq_* outputs held stable until dresp_addr_ok.
  - addr_ok without data_ok: go to WAIT, dreq_valid=0.
  - addr_ok with data_ok in the same cycle: go to DONE.
- WAIT: data_ok goes to DONE; data_ok is ignored in every other state.
- DONE:
  - out_valid=1 for exactly one cycle, then return to IDLE.
  - in_ready=0 in REQ/WAIT/DONE, so back-to-back ops have a minimum of 2 idle-to-idle cycles.
  - out_rdata/out_fault hold until the next DONE.
- Size and shift: size=funct3[1:0]; sh=addr[2:0].
  - Store: strobe = ((1<<(1<<size))-1) << sh; dreq_data = wdata << (8*sh).
- Load: r = dresp_data >> (8*sh), captured on data_ok.
  - funct3 000/001/010: sign-extend from 8/16/32 bits.
  - funct3 011: r.
  - funct3 100/101/110: zero-extend from 8/16/32 bits.
- Minimum latency (addr_ok and data_ok same cycle as first REQ): accept cycle N, REQ N+1, out_valid N+2.

Test Plan:
- lb, addr=0x80000003, dresp_data=0x00000000_F0000000 (addr_ok and data_ok together) -> strobe=0, size=0, out_rdata=0xFFFFFFFF_FFFFFFF0, out_valid 2 cycles after accept.
- lhu, addr=0x...06, dresp_data=0x8001_0000_0000_0000 -> out_rdata=0x0000_0000_0000_8001.
- sw, addr=0x...04, wdata=0x12345678 -> strobe=0xF0, dreq_data=0x12345678_00000000.
- sd with addr_ok delayed 3 cycles then data_ok 2 cycles later -> dreq_* stable throughout REQ, dreq_valid=0 in WAIT, in_ready=0 until DONE passes.
- lw, addr=0x...02 -> no dreq_valid; out_valid with out_fault=1. Load funct3=111 -> same response.
- reset=0 asserted in WAIT, then released; a stale data_ok pulse in IDLE -> no out_valid; next op completes normally.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
// Groups the memory-stage handshake and the data-bus request/response signals
// used by mem_access_unit.
//   master : the memory access unit (drives in_ready, dreq_*, out_*)
//   slave  : its environment, i.e. the pipeline and the data bus
// Pipeline side : in_valid/in_ready, is_mem_read, is_mem_write, mem_mode,
//                 addr, wdata, out_valid, out_rdata, out_fault
// Bus side      : dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
//                 dresp_addr_ok, dresp_data_ok, dresp_data
// -----------------------------------------------------------------------------
interface mem_access_unit_if #(
    parameter int XLEN = 64
);
    logic              in_valid;
    logic              in_ready;
    logic              is_mem_read;
    logic              is_mem_write;
    logic [3:0]        mem_mode;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;

    logic              dreq_valid;
    logic [XLEN-1:0]   dreq_addr;
    logic [2:0]        dreq_size;
    logic [XLEN/8-1:0] dreq_strobe;
    logic [XLEN-1:0]   dreq_data;
    logic              dresp_addr_ok;
    logic              dresp_data_ok;
    logic [XLEN-1:0]   dresp_data;

    logic              out_valid;
    logic [XLEN-1:0]   out_rdata;
    logic              out_fault;

    modport master (
        input  in_valid, is_mem_read, is_mem_write, mem_mode, addr, wdata,
        input  dresp_addr_ok, dresp_data_ok, dresp_data,
        output in_ready, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output out_valid, out_rdata, out_fault
    );

    modport slave (
        output in_valid, is_mem_read, is_mem_write, mem_mode, addr, wdata,
        output dresp_addr_ok, dresp_data_ok, dresp_data,
        input  in_ready, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  out_valid, out_rdata, out_fault
    );
endinterface

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Memory-stage engine: accepts one load/store op at a time, issues a single
// data-bus transaction for it, and returns the aligned and extended load
// result (or a fault) as a one-cycle out_valid pulse. in_ready is high only
// while idle, which stalls the pipeline for the duration of the transaction.
// Ports:
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : mem_access_unit_if.master (pipeline handshake + data bus)
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int XLEN = 64
) (
    input  logic               clk,
    input  logic               reset,
    mem_access_unit_if.master  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      state_q, state_d;
    logic            is_read_q;
    logic [2:0]      funct3_q;
    logic [2:0]      sh_q;
    logic [XLEN-1:0] dreq_addr_q;
    logic [2:0]      dreq_size_q;
    logic [7:0]      dreq_strobe_q;
    logic [XLEN-1:0] dreq_data_q;
    logic [XLEN-1:0] rdata_q;
    logic            fault_q;

    // Decode of the op presented in IDLE. Write wins if the decoder raises both.
    logic       is_wr, is_rd;
    logic [2:0] funct3;
    logic [1:0] size;
    logic [2:0] sh;
    logic       misaligned, fault_in, go_bus, accept, complete;
    logic [7:0] strobe_base;

    assign is_wr  = bus.is_mem_write;
    assign is_rd  = bus.is_mem_read & ~bus.is_mem_write;
    assign funct3 = bus.mem_mode[2:0];
    assign size   = funct3[1:0];
    assign sh     = bus.addr[2:0];
    assign accept = (state_q == S_IDLE) && bus.in_valid;

    // The write bit of mem_mode duplicates is_mem_write; only funct3 is used.
    logic unused_mode_write;
    assign unused_mode_write = bus.mem_mode[3];

    // NOTE: every signal assigned in always_comb gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        misaligned  = 1'b0;
        strobe_base = 8'h01;
        case (size)
            2'd0: begin misaligned = 1'b0;        strobe_base = 8'h01; end
            2'd1: begin misaligned = sh[0];       strobe_base = 8'h03; end
            2'd2: begin misaligned = |sh[1:0];    strobe_base = 8'h0F; end
            default: begin misaligned = |sh;     strobe_base = 8'hFF; end
        endcase
    end

    assign fault_in = (is_rd | is_wr) &
                      (misaligned | (is_rd & (funct3 == 3'b111)) | (is_wr & funct3[2]));
    assign go_bus   = (is_rd | is_wr) & ~fault_in;

    assign complete = ((state_q == S_REQ) && bus.dresp_addr_ok && bus.dresp_data_ok) ||
                      ((state_q == S_WAIT) && bus.dresp_data_ok);

    // Load alignment: shift the addressed bytes down to lane 0, then extend.
    logic [XLEN-1:0] load_shift, load_ext;
    assign load_shift = bus.dresp_data >> {sh_q, 3'b000};

    always_comb begin
        load_ext = load_shift;
        case (funct3_q)
            3'b000:  load_ext = {{56{load_shift[7]}},  load_shift[7:0]};
            3'b001:  load_ext = {{48{load_shift[15]}}, load_shift[15:0]};
            3'b010:  load_ext = {{32{load_shift[31]}}, load_shift[31:0]};
            3'b100:  load_ext = {56'd0, load_shift[7:0]};
            3'b101:  load_ext = {48'd0, load_shift[15:0]};
            3'b110:  load_ext = {32'd0, load_shift[31:0]};
            default: load_ext = load_shift;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.in_valid) state_d = go_bus ? S_REQ : S_DONE;
            S_REQ:   if (bus.dresp_addr_ok) state_d = bus.dresp_data_ok ? S_DONE : S_WAIT;
            S_WAIT:  if (bus.dresp_data_ok) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            is_read_q     <= 1'b0;
            funct3_q      <= 3'd0;
            sh_q          <= 3'd0;
            dreq_addr_q   <= '0;
            dreq_size_q   <= 3'd0;
            dreq_strobe_q <= 8'd0;
            dreq_data_q   <= '0;
            rdata_q       <= '0;
            fault_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                is_read_q     <= is_rd;
                funct3_q      <= funct3;
                sh_q          <= sh;
                dreq_addr_q   <= bus.addr;
                dreq_size_q   <= {1'b0, size};
                dreq_strobe_q <= is_wr ? (strobe_base << sh) : 8'd0;
                dreq_data_q   <= is_wr ? (bus.wdata << {sh, 3'b000}) : '0;
                // Ops that skip the bus finish next cycle; publish their result now.
                if (!go_bus) begin
                    fault_q <= fault_in;
                    rdata_q <= '0;
                end
            end
            if (complete) begin
                fault_q <= 1'b0;
                rdata_q <= is_read_q ? load_ext : '0;
            end
        end
    end

    assign bus.in_ready    = (state_q == S_IDLE);
    assign bus.dreq_valid  = (state_q == S_REQ);
    assign bus.out_valid   = (state_q == S_DONE);
    assign bus.dreq_addr   = dreq_addr_q;
    assign bus.dreq_size   = dreq_size_q;
    assign bus.dreq_strobe = dreq_strobe_q;
    assign bus.dreq_data   = dreq_data_q;
    assign bus.out_rdata   = rdata_q;
    assign bus.out_fault   = fault_q;
endmodule
